// File: rtl/xadc_pkg.sv
// Shared definitions for the XADC V/I pairing front-end: channel ids, pair layout,
// pairer FSM states and a saturating counter helper.
package xadc_pkg;

    localparam logic [4:0] XADC_TID_VPV = 5'h10;
    localparam logic [4:0] XADC_TID_IPV = 5'h18;

    typedef struct packed {
        logic [15:0] i;
        logic [15:0] v;
    } vi_pair_t;

    typedef enum logic {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } pairer_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] val);
        return (val == 16'hFFFF) ? val : val + 16'd1;
    endfunction

endpackage

// File: rtl/xadc_chan_accum.sv
// Per-channel boxcar accumulator: sums up to 2^AVG_LOG2 samples, flags drops once full.
// Next-state values are exported so the owner can react in the same cycle a window fills.
module xadc_chan_accum
    import xadc_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int AVG_LOG2 = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       sample_en,
    input  logic [DATA_W-1:0]          sample,
    output logic [DATA_W+AVG_LOG2-1:0] acc_nxt,
    output logic                       full_nxt,
    output logic                       drop
);

    localparam int ACC_W = DATA_W + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] FULL_N = CNT_W'(2 ** AVG_LOG2);

    logic [ACC_W-1:0] acc_r;
    logic [ACC_W-1:0] acc_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             full_s;
    logic             drop_s;

    assign full_s = (cnt_r == FULL_N);

    // Next accumulator/count: clear wins, otherwise add or drop an accepted sample
    always_comb begin
        acc_nxt_s = acc_r;
        cnt_nxt_s = cnt_r;
        drop_s    = 1'b0;
        if (clear) begin
            acc_nxt_s = '0;
            cnt_nxt_s = '0;
        end else if (sample_en) begin
            if (full_s) begin
                drop_s = 1'b1;
            end else begin
                acc_nxt_s = acc_r + ACC_W'(sample);
                cnt_nxt_s = cnt_r + CNT_W'(1);
            end
        end else begin
            drop_s = 1'b0;
        end
    end

    // Accumulator and sample-count registers
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r <= '0;
            cnt_r <= '0;
        end else begin
            acc_r <= acc_nxt_s;
            cnt_r <= cnt_nxt_s;
        end
    end

    assign acc_nxt  = acc_nxt_s;
    assign full_nxt = (cnt_nxt_s == FULL_N);
    assign drop     = drop_s;

endmodule

// File: rtl/xadc_vi_pairer.sv
// Splits the XADC sequencer stream into panel voltage/current channels, averages a window
// of each and presents one aligned {I,V} pair per window to the parameter estimator.
module xadc_vi_pairer
    import xadc_pkg::*;
#(
    parameter int         DATA_W   = 16,
    parameter int         AVG_LOG2 = 2,
    parameter logic [4:0] V_TID    = XADC_TID_VPV,
    parameter logic [4:0] I_TID    = XADC_TID_IPV
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic [DATA_W-1:0]     seq_in_xadc_tdata,
    input  logic [4:0]            seq_in_xadc_tid,
    input  logic                  seq_in_xadc_tvalid,
    output logic                  seq_in_xadc_tready,
    output logic [2*DATA_W-1:0]   vi_out_tdata,
    output logic                  vi_out_tvalid,
    input  logic                  vi_out_tready,
    output logic [15:0]           drop_cnt,
    output logic [15:0]           pair_cnt
);

    localparam int ACC_W = DATA_W + AVG_LOG2;

    pairer_state_t       state_r;
    pairer_state_t       state_nxt_s;
    logic                xfer_s;
    logic                v_en_s;
    logic                i_en_s;
    logic                clear_s;
    logic [ACC_W-1:0]    v_acc_nxt_s;
    logic [ACC_W-1:0]    i_acc_nxt_s;
    logic                v_full_nxt_s;
    logic                i_full_nxt_s;
    logic                v_drop_s;
    logic                i_drop_s;
    logic [2*DATA_W-1:0] tdata_r;
    logic [15:0]         drop_cnt_r;
    logic [15:0]         pair_cnt_r;

    // Input is only held off while a pair waits, and during the reset cycle itself
    assign seq_in_xadc_tready = (state_r == COLLECT) & ~ap_rst;
    assign xfer_s  = seq_in_xadc_tvalid & seq_in_xadc_tready;
    assign v_en_s  = xfer_s & (seq_in_xadc_tid == V_TID);
    assign i_en_s  = xfer_s & (seq_in_xadc_tid == I_TID);
    assign clear_s = (state_r == EMIT) & vi_out_tready;

    xadc_chan_accum #(.DATA_W(DATA_W), .AVG_LOG2(AVG_LOG2)) u_v_accum (
        .clk       (ap_clk),
        .rst       (ap_rst),
        .clear     (clear_s),
        .sample_en (v_en_s),
        .sample    (seq_in_xadc_tdata),
        .acc_nxt   (v_acc_nxt_s),
        .full_nxt  (v_full_nxt_s),
        .drop      (v_drop_s)
    );

    xadc_chan_accum #(.DATA_W(DATA_W), .AVG_LOG2(AVG_LOG2)) u_i_accum (
        .clk       (ap_clk),
        .rst       (ap_rst),
        .clear     (clear_s),
        .sample_en (i_en_s),
        .sample    (seq_in_xadc_tdata),
        .acc_nxt   (i_acc_nxt_s),
        .full_nxt  (i_full_nxt_s),
        .drop      (i_drop_s)
    );

    // Next-state: leave COLLECT as soon as both windows complete, leave EMIT on handshake
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            COLLECT: begin
                if (v_full_nxt_s & i_full_nxt_s) begin
                    state_nxt_s = EMIT;
                end else begin
                    state_nxt_s = COLLECT;
                end
            end
            EMIT: begin
                if (vi_out_tready) begin
                    state_nxt_s = COLLECT;
                end else begin
                    state_nxt_s = EMIT;
                end
            end
            default: state_nxt_s = COLLECT;
        endcase
    end

    // State register
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_r <= COLLECT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Output pair is captured from the completing sums, so it stays frozen while stalled
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            tdata_r <= '0;
        end else if ((state_r == COLLECT) && (state_nxt_s == EMIT)) begin
            tdata_r <= {i_acc_nxt_s[AVG_LOG2 +: DATA_W], v_acc_nxt_s[AVG_LOG2 +: DATA_W]};
        end else begin
            tdata_r <= tdata_r;
        end
    end

    // Drop counter saturates; pair counter wraps
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            drop_cnt_r <= 16'd0;
            pair_cnt_r <= 16'd0;
        end else begin
            if (v_drop_s | i_drop_s) begin
                drop_cnt_r <= sat_inc16(drop_cnt_r);
            end else begin
                drop_cnt_r <= drop_cnt_r;
            end
            if (clear_s) begin
                pair_cnt_r <= pair_cnt_r + 16'd1;
            end else begin
                pair_cnt_r <= pair_cnt_r;
            end
        end
    end

    assign vi_out_tdata  = tdata_r;
    assign vi_out_tvalid = (state_r == EMIT);
    assign drop_cnt      = drop_cnt_r;
    assign pair_cnt      = pair_cnt_r;

endmodule
